// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add unit: FSM state encoding,
// exception flag bit positions and constant builders for special encodings.
package fp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } fp_state_e;

    // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}.
    localparam int unsigned FLG_NV = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 0;

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    // Result is 128 bits wide; callers cast down to their word width.
    function automatic logic [127:0] qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [127:0] v;
        v = ((128'd1 << exp_w) - 128'd1) << man_w;
        v = v | (128'd1 << (man_w - 1));
        return v;
    endfunction

    // Positive infinity: exponent all ones, fraction zero.
    function automatic logic [127:0] inf(input int unsigned exp_w, input int unsigned man_w);
        return ((128'd1 << exp_w) - 128'd1) << man_w;
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even and final packing.
//   sign_i, exp_i        : result sign and biased working exponent (1 for subnormals)
//   mant_i               : {hidden, fraction}
//   g_i, r_i, s_i        : guard, round and sticky bits below the fraction
//   z_o                  : packed result (infinity on overflow)
//   overflow_o           : rounded exponent reached all ones
//   inexact_o            : any discarded bit was set, or overflow
//   tiny_o               : rounded result is subnormal or zero
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W  = 1 + EXP_W + MAN_W,
    localparam int unsigned EW = EXP_W + 2
) (
    input  logic          sign_i,
    input  logic [EW-1:0] exp_i,
    input  logic [MAN_W:0] mant_i,
    input  logic          g_i,
    input  logic          r_i,
    input  logic          s_i,
    output logic [W-1:0]  z_o,
    output logic          overflow_o,
    output logic          inexact_o,
    output logic          tiny_o
);

    localparam logic [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [W-1:0]  INF     = W'(inf(EXP_W, MAN_W));

    logic            inc;
    logic [MAN_W+1:0] sum;
    logic [MAN_W:0]  mant_r;
    logic [EW-1:0]   exp_r;
    logic [EXP_W-1:0] exp_field;

    always_comb begin
        inc = g_i & (r_i | s_i | mant_i[0]);
        sum = {1'b0, mant_i} + {{(MAN_W + 1){1'b0}}, inc};
        // Carry out of the mantissa: value is exactly 1.0 * 2^(exp+1).
        if (sum[MAN_W+1]) begin
            mant_r = sum[MAN_W+1:1];
            exp_r  = exp_i + EW'(1);
        end else begin
            mant_r = sum[MAN_W:0];
            exp_r  = exp_i;
        end
        // Hidden bit clear means subnormal or zero: encoded exponent 0.
        exp_field  = mant_r[MAN_W] ? exp_r[EXP_W-1:0] : '0;
        z_o        = {sign_i, exp_field, mant_r[MAN_W-1:0]};
        overflow_o = 1'b0;
        inexact_o  = g_i | r_i | s_i;
        tiny_o     = ~mant_r[MAN_W];
        if (exp_r >= EXP_MAX) begin
            z_o        = INF | {sign_i, {(W - 1){1'b0}}};
            overflow_o = 1'b1;
            inexact_o  = 1'b1;
            tiny_o     = 1'b0;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor with valid/ready on both sides.
//   clk, rst (sync, active-low)
//   in_valid/in_ready, a, b, sub : operation request (sub flips B's sign at capture)
//   out_valid/out_ready, z, flags: result, flags = {invalid, overflow, underflow, inexact}
// One operation in flight; alignment and normalisation shift one bit per cycle.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    localparam int unsigned W  = 1 + EXP_W + MAN_W,
    localparam int unsigned MW = MAN_W + 5,
    localparam int unsigned EW = EXP_W + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic [3:0]   flags
);

    localparam logic [W-1:0]  QNAN      = W'(qnan(EXP_W, MAN_W));
    localparam logic [EW-1:0] ALIGN_MAX = EW'(MAN_W + 3);

    fp_state_e       state_q, state_d;
    logic            live_q;
    logic [W-1:0]    a_q, a_d, b_q, b_d, z_q, z_d;
    logic [3:0]      flags_q, flags_d;
    // x holds the larger-exponent operand; after ADD it holds the result.
    logic            sx_q, sx_d, sy_q, sy_d;
    logic [MW-1:0]   mx_q, mx_d, my_q, my_d;
    logic [EW-1:0]   exp_q, exp_d, diff_q, diff_d;

    // Operand decode used in UNPACK.
    logic [EXP_W-1:0] ea_f, eb_f;
    logic [MAN_W-1:0] fa, fb;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic [EW-1:0]    ea, eb;
    logic [MW-1:0]    ma, mb;

    logic [W-1:0]     rnd_z;
    logic             rnd_of, rnd_nx, rnd_tiny;

    assign in_ready  = live_q && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign z         = z_q;
    assign flags     = flags_q;

    always_comb begin
        ea_f   = a_q[W-2:MAN_W];
        eb_f   = b_q[W-2:MAN_W];
        fa     = a_q[MAN_W-1:0];
        fb     = b_q[MAN_W-1:0];
        a_nan  = (&ea_f) & (|fa);
        b_nan  = (&eb_f) & (|fb);
        a_snan = a_nan & ~fa[MAN_W-1];
        b_snan = b_nan & ~fb[MAN_W-1];
        a_inf  = (&ea_f) & ~(|fa);
        b_inf  = (&eb_f) & ~(|fb);
        // Subnormals share the exponent of the smallest normal.
        ea     = (ea_f == '0) ? EW'(1) : {2'b00, ea_f};
        eb     = (eb_f == '0) ? EW'(1) : {2'b00, eb_f};
        ma     = {1'b0, |ea_f, fa, 3'b000};
        mb     = {1'b0, |eb_f, fb, 3'b000};
    end

    fp_round_rne #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
    ) u_round (
        .sign_i    (sx_q),
        .exp_i     (exp_q),
        .mant_i    (mx_q[MW-2:3]),
        .g_i       (mx_q[2]),
        .r_i       (mx_q[1]),
        .s_i       (mx_q[0]),
        .z_o       (rnd_z),
        .overflow_o(rnd_of),
        .inexact_o (rnd_nx),
        .tiny_o    (rnd_tiny)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        flags_d = flags_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        mx_d    = mx_q;
        my_d    = my_q;
        exp_d   = exp_q;
        diff_d  = diff_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = {b[W-1] ^ sub, b[W-2:0]};
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                state_d = StDone;
                flags_d = '0;
                if (a_nan || b_nan) begin
                    z_d             = QNAN;
                    flags_d[FLG_NV] = a_snan | b_snan;
                end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
                    z_d             = QNAN;
                    flags_d[FLG_NV] = 1'b1;
                end else if (a_inf) begin
                    z_d = a_q;
                end else if (b_inf) begin
                    z_d = b_q;
                end else begin
                    state_d = StAlign;
                    if (ea >= eb) begin
                        sx_d = a_q[W-1]; mx_d = ma; sy_d = b_q[W-1]; my_d = mb;
                        exp_d = ea; diff_d = ea - eb;
                    end else begin
                        sx_d = b_q[W-1]; mx_d = mb; sy_d = a_q[W-1]; my_d = ma;
                        exp_d = eb; diff_d = eb - ea;
                    end
                end
            end
            StAlign: begin
                if (diff_q == '0) begin
                    state_d = StAdd;
                end else if (diff_q > ALIGN_MAX) begin
                    // Everything lands below the sticky position.
                    my_d    = {{(MW - 1){1'b0}}, |my_q};
                    diff_d  = '0;
                    state_d = StAdd;
                end else begin
                    my_d   = {1'b0, my_q[MW-1:2], my_q[1] | my_q[0]};
                    diff_d = diff_q - EW'(1);
                    if (diff_q == EW'(1)) begin
                        state_d = StAdd;
                    end
                end
            end
            StAdd: begin
                if (sx_q == sy_q) begin
                    mx_d = mx_q + my_q;
                end else if (mx_q >= my_q) begin
                    mx_d = mx_q - my_q;
                    // Exact cancellation yields +0.
                    if (mx_q == my_q) begin
                        sx_d = 1'b0;
                    end
                end else begin
                    mx_d = my_q - mx_q;
                    sx_d = sy_q;
                end
                state_d = StNorm;
            end
            StNorm: begin
                if (mx_q[MW-1]) begin
                    mx_d    = {1'b0, mx_q[MW-1:2], mx_q[1] | mx_q[0]};
                    exp_d   = exp_q + EW'(1);
                    state_d = StRound;
                end else if (mx_q == '0) begin
                    // Zero result: skip the left-shift walk down to exponent 1.
                    exp_d   = EW'(1);
                    state_d = StRound;
                end else if (!mx_q[MW-2] && (exp_q > EW'(1))) begin
                    mx_d  = {mx_q[MW-2:0], 1'b0};
                    exp_d = exp_q - EW'(1);
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                z_d             = rnd_z;
                flags_d         = '0;
                flags_d[FLG_OF] = rnd_of;
                flags_d[FLG_UF] = rnd_tiny & rnd_nx;
                flags_d[FLG_NX] = rnd_nx;
                state_d         = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            live_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            flags_q <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
            exp_q   <= '0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            flags_q <= flags_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            exp_q   <= exp_d;
            diff_q  <= diff_d;
        end
    end

endmodule
